// File: rtl/elevator_call_scheduler_pkg.sv
// Shared types for the elevator call scheduler: FSM state encoding.
package elevator_call_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MOVE = 2'b01,
        DOOR = 2'b10
    } state_t;

endpackage

// File: rtl/elevator_dir_select.sv
// Combinational view of the pending calls relative to the car:
// is the current floor called, and is anything called above or below it.
module elevator_dir_select #(
    parameter int NUM_FLOORS = 7,
    parameter int FLOOR_W    = 3
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic                  hit_cur,
    output logic                  above,
    output logic                  below
);

    logic [NUM_FLOORS-1:0] hit_mask;
    logic [NUM_FLOORS-1:0] above_mask;
    logic [NUM_FLOORS-1:0] below_mask;

    // Bit i stands for floor i+1, so each bit compares its own floor number.
    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
        localparam logic [FLOOR_W-1:0] FLOOR_NUM = FLOOR_W'(i + 1);
        assign hit_mask[i]   = pending[i] && (cur_floor == FLOOR_NUM);
        assign above_mask[i] = pending[i] && (FLOOR_NUM > cur_floor);
        assign below_mask[i] = pending[i] && (FLOOR_NUM < cur_floor);
    end

    assign hit_cur = |hit_mask;
    assign above   = |above_mask;
    assign below   = |below_mask;

endmodule

// File: rtl/elevator_call_scheduler.sv
// Collective (SCAN) elevator scheduler: latches floor calls, moves the car
// one floor at a time and holds the door open at every called floor.
module elevator_call_scheduler
    import elevator_call_scheduler_pkg::*;
#(
    parameter int NUM_FLOORS = 7,
    parameter int FLOOR_W    = 3,
    parameter int STEP_TICKS = 250_000_000,
    parameter int DOOR_TICKS = 100_000_000,
    parameter int CNT_W      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic                  run_en,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      tick_q, tick_d;
    logic [FLOOR_W-1:0]    cur_floor_q, cur_floor_d;
    logic                  dir_up_q, dir_up_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] cur_mask;
    logic                  clr_en;
    logic                  hit_cur;
    logic                  above;
    logic                  below;

    elevator_dir_select #(
        .NUM_FLOORS(NUM_FLOORS),
        .FLOOR_W   (FLOOR_W)
    ) u_dir_select (
        .pending  (pending_q),
        .cur_floor(cur_floor_q),
        .hit_cur  (hit_cur),
        .above    (above),
        .below    (below)
    );

    always_comb begin
        cur_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cur_mask[i] = (cur_floor_q == FLOOR_W'(i + 1));
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        cur_floor_d = cur_floor_q;
        dir_up_d    = dir_up_q;
        clr_en      = 1'b0;

        case (state_q)
            IDLE: begin
                // Serve the current floor first, then keep sweeping, then reverse.
                if (hit_cur) begin
                    state_d = DOOR;
                    tick_d  = '0;
                    clr_en  = 1'b1;
                end else if (dir_up_q && above) begin
                    state_d = MOVE;
                    tick_d  = '0;
                end else if (!dir_up_q && below) begin
                    state_d = MOVE;
                    tick_d  = '0;
                end else if (above) begin
                    state_d  = MOVE;
                    tick_d   = '0;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = MOVE;
                    tick_d   = '0;
                    dir_up_d = 1'b0;
                end
            end

            MOVE: begin
                if (run_en) begin
                    if (tick_q == CNT_W'(STEP_TICKS - 1)) begin
                        cur_floor_d = dir_up_q ? cur_floor_q + FLOOR_W'(1)
                                               : cur_floor_q - FLOOR_W'(1);
                        tick_d      = '0;
                        state_d     = IDLE;
                    end else begin
                        tick_d = tick_q + CNT_W'(1);
                    end
                end
            end

            DOOR: begin
                clr_en = 1'b1;
                // A fresh call for this floor keeps the door open a full period.
                if ((req & cur_mask) != '0) begin
                    tick_d = '0;
                end else if (tick_q == CNT_W'(DOOR_TICKS - 1)) begin
                    tick_d  = '0;
                    state_d = IDLE;
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase

        pending_d = (pending_q | req) & ~(clr_en ? cur_mask : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            cur_floor_q <= FLOOR_W'(1);
            dir_up_q    <= 1'b1;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            cur_floor_q <= cur_floor_d;
            dir_up_q    <= dir_up_d;
            pending_q   <= pending_d;
        end
    end

    assign cur_floor = cur_floor_q;
    assign dir_up    = dir_up_q;
    assign moving    = (state_q == MOVE);
    assign door_open = (state_q == DOOR);
    assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler: directed scenarios plus a
// scoreboard of expected door openings (floor and direction, in order).
module tb_elevator_call_scheduler;

    localparam int NUM_FLOORS = 7;
    localparam int FLOOR_W    = 3;
    localparam int STEP_TICKS = 4;
    localparam int DOOR_TICKS = 3;
    localparam int CNT_W      = 4;

    logic                  clk;
    logic                  rst;
    logic [NUM_FLOORS-1:0] req;
    logic                  run_en;
    logic [FLOOR_W-1:0]    cur_floor;
    logic                  dir_up;
    logic                  moving;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] pending;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_e;
    logic       door_prev;
    int         door_cnt;

    elevator_call_scheduler #(
        .NUM_FLOORS(NUM_FLOORS),
        .FLOOR_W   (FLOOR_W),
        .STEP_TICKS(STEP_TICKS),
        .DOOR_TICKS(DOOR_TICKS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .run_en   (run_en),
        .cur_floor(cur_floor),
        .dir_up   (dir_up),
        .moving   (moving),
        .door_open(door_open),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NUM_FLOORS-1:0] floorBit(input int f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        if (f >= 1 && f <= NUM_FLOORS) m[f-1] = 1'b1;
        return m;
    endfunction

    function automatic logic [7:0] doorEntry(input logic d, input int f);
        return {4'b0000, d, FLOOR_W'(f)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [NUM_FLOORS-1:0] mask);
        req = mask;
        @(negedge clk);
        req = '0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (n < budget && (moving || door_open || pending != '0)) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkOutput("idle_timeout", {moving, door_open, pending}, 0);
    endtask

    task automatic waitMovingAt(input int f, input int budget);
        int n;
        n = 0;
        while (n < budget && !(moving && cur_floor == FLOOR_W'(f))) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkOutput("reach_floor", {moving, cur_floor}, {1'b1, FLOOR_W'(f)});
    endtask

    // Every rising door edge must match the next expected (direction, floor).
    always @(negedge clk) begin
        if (rst) begin
            door_prev <= 1'b0;
        end else begin
            if (door_open && !door_prev) begin
                if (exp_q.size() > 0) exp_e = exp_q.pop_front();
                else exp_e = 8'hFF;
                checkOutput("door_seq", {4'b0000, dir_up, cur_floor}, exp_e);
                checkOutput("door_clr", pending & floorBit(int'(cur_floor)), 0);
            end
            door_prev <= door_open;
        end
    end

    initial begin
        rst    = 1'b1;
        run_en = 1'b1;
        req    = '0;
        tick(2);
        rst = 1'b0;

        // Reset state held while idle.
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput("idle_state", {dir_up, cur_floor, pending, moving, door_open},
                        {1'b1, 3'd1, 7'd0, 1'b0, 1'b0});
        end

        // Call at the current floor: door two edges after the request.
        exp_q.push_back(doorEntry(1'b1, 1));
        applyStimulus(floorBit(1));
        checkOutput("same_pend", {pending, door_open}, {floorBit(1), 1'b0});
        tick(1);
        checkOutput("same_door", {pending, door_open}, {7'd0, 1'b1});
        door_cnt = 1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            door_cnt += int'(door_open);
        end
        checkOutput("door_len", door_cnt, DOOR_TICKS);
        waitIdle(50);

        // Floor 1 to floor 5: one floor every STEP_TICKS+1 cycles.
        exp_q.push_back(doorEntry(1'b1, 5));
        applyStimulus(floorBit(5));
        checkOutput("decide_gap", moving, 0);
        for (int k = 1; k <= 4; k++) begin
            tick(4);
            checkOutput("step_before", {moving, cur_floor}, {1'b1, FLOOR_W'(k)});
            tick(1);
            checkOutput("step_after", {dir_up, cur_floor}, {1'b1, FLOOR_W'(k + 1)});
        end
        checkOutput("arrive_pend", {pending, door_open}, {floorBit(5), 1'b0});
        tick(1);
        checkOutput("arrive_door", {pending, door_open}, {7'd0, 1'b1});
        waitIdle(50);

        // Down to floor 1 with a 20-cycle run_en freeze on the first step.
        exp_q.push_back(doorEntry(1'b0, 1));
        applyStimulus(floorBit(1));
        tick(1);
        checkOutput("down_start", {moving, dir_up}, {1'b1, 1'b0});
        tick(1);
        run_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checkOutput("frozen", {moving, cur_floor}, {1'b1, 3'd5});
        end
        run_en = 1'b1;
        tick(2);
        checkOutput("resume_hold", cur_floor, 5);
        tick(1);
        checkOutput("resume_step", cur_floor, 4);
        waitIdle(100);

        // SCAN: going up past 3 toward 6, calls at 2 and 5 -> doors 5, 6, then 2.
        exp_q.push_back(doorEntry(1'b1, 5));
        exp_q.push_back(doorEntry(1'b1, 6));
        exp_q.push_back(doorEntry(1'b0, 2));
        applyStimulus(floorBit(6));
        waitMovingAt(3, 50);
        checkOutput("scan_dir", dir_up, 1);
        applyStimulus(floorBit(2) | floorBit(5));
        checkOutput("scan_pend", pending, floorBit(2) | floorBit(5) | floorBit(6));
        waitIdle(200);
        checkOutput("scan_end", {dir_up, cur_floor}, {1'b0, 3'd2});

        // Door hold: re-call the current floor on the second door cycle.
        exp_q.push_back(doorEntry(1'b0, 2));
        applyStimulus(floorBit(2));
        tick(1);
        checkOutput("hold_d1", door_open, 1);
        tick(1);
        checkOutput("hold_d2", door_open, 1);
        applyStimulus(floorBit(2));
        checkOutput("hold_absorb", {door_open, pending}, {1'b1, 7'd0});
        tick(1);
        checkOutput("hold_d4", door_open, 1);
        tick(1);
        checkOutput("hold_d5", door_open, 1);
        tick(1);
        checkOutput("hold_close", door_open, 0);
        waitIdle(50);

        // Reset in the middle of a move discards everything.
        applyStimulus(floorBit(6));
        waitMovingAt(3, 50);
        rst = 1'b1;
        tick(1);
        checkOutput("rst_mid", {dir_up, cur_floor, pending, moving, door_open},
                    {1'b1, 3'd1, 7'd0, 1'b0, 1'b0});
        rst = 1'b0;
        tick(3);
        checkOutput("rst_after", {cur_floor, pending, moving, door_open},
                    {3'd1, 7'd0, 1'b0, 1'b0});

        checkOutput("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
